dif_radix2_64p_da_ctrl: RTL and testbench



---
 rtl/dif_radix2_64p_da_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dif_radix2_64p_da_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dif_radix2_64p_da_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dif_radix2_64p_da_ctrl
//  Purpose  : Control sequencer for the 64-point radix-2 DIF data arranger
//             (8 banks x 8 entries). Writes a natural-order frame into the
//             arranger, then reads it back in transposed order, or in
//             bit-reversed order when DIF_DA_CTRL_BITREV_EN is defined.
//  Options  : DIF_DA_CTRL_BITREV_EN - bit-reversed read order
//  Revision : 1.0 - initial release
// ============================================================================
module dif_radix2_64p_da_ctrl #(
  parameter int         RD_LAT   = 1,     // read issue -> dout valid, 0..3
  parameter logic [3:0] IDLE_SEL = 4'd8   // select value meaning "no bank"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       in_last_o,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic       out_first_o,
  output logic       out_last_o,
  output logic [3:0] wen_ctrl_o,
  output logic [2:0] waddr_ctrl_o,
  output logic [3:0] ren_ctrl_o,
  output logic [2:0] raddr_ctrl_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd63;

  state_t     state_q, state_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;

  logic       rd_fire;      // read issued this cycle
  logic       rd_first;     // issued read is index 0
  logic       rd_last;      // issued read is index 63
  logic [3:0] rd_bank;      // decoded bank for read index rd_cnt_q
  logic [2:0] rd_entry;     // decoded entry for read index rd_cnt_q

  logic       pipe_vld;     // latency-pipe outputs
  logic       pipe_fst;
  logic       pipe_lst;
  logic       pipe_any;     // any read still travelling through the pipe

  // Read-order decode: read index m -> storage sample n -> (bank, entry).
  // Samples are stored with bank = n[2:0], entry = n[5:3].
`ifdef DIF_DA_CTRL_BITREV_EN
  logic [5:0] rd_idx;
  assign rd_idx   = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2],
                     rd_cnt_q[3], rd_cnt_q[4], rd_cnt_q[5]};
  assign rd_bank  = {1'b0, rd_idx[2:0]};
  assign rd_entry = rd_idx[5:3];
`else
  // Transpose: n = {m[2:0], m[5:3]}, so bank = m[5:3] and entry = m[2:0].
  assign rd_bank  = {1'b0, rd_cnt_q[5:3]};
  assign rd_entry = rd_cnt_q[2:0];
`endif

  assign rd_first = rd_fire && (rd_cnt_q == 6'd0);
  assign rd_last  = rd_fire && (rd_cnt_q == LAST_IDX);

  // State, write counter and read counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      wr_cnt_q <= 6'd0;
      rd_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Next-state logic and same-cycle arranger controls. While reset is held
  // every output is forced to its reset value so nothing fires into the
  // arranger from a stale state.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_fire      = 1'b0;
    in_ready_o   = 1'b0;
    in_last_o    = 1'b0;
    wen_ctrl_o   = IDLE_SEL;
    waddr_ctrl_o = wr_cnt_q[5:3];
    ren_ctrl_o   = IDLE_SEL;
    raddr_ctrl_o = rd_entry;

    if (!rst_n) begin
      in_ready_o   = 1'b1;
      waddr_ctrl_o = 3'd0;
      raddr_ctrl_o = 3'd0;
    end else begin
      case (state_q)
        ST_FILL: begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            wen_ctrl_o = {1'b0, wr_cnt_q[2:0]};
            wr_cnt_d   = wr_cnt_q + 6'd1;   // wraps to 0 after sample 63
            if (wr_cnt_q == LAST_IDX) begin
              in_last_o = 1'b1;
              state_d   = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // in_valid_i is deliberately ignored here: the frame is full.
          if (out_ready_i) begin
            rd_fire    = 1'b1;
            ren_ctrl_o = rd_bank;
            rd_cnt_d   = rd_cnt_q + 6'd1;   // wraps to 0 after read 63
            if (rd_cnt_q == LAST_IDX) begin
              state_d = ST_FILL;
            end
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  // Fixed-latency valid/first/last pipe. out_ready only throttles issue; the
  // pipe never stalls, so downstream must take every beat.
  generate
    if (RD_LAT == 0) begin : g_lat_zero
      assign pipe_vld = rd_fire;
      assign pipe_fst = rd_first;
      assign pipe_lst = rd_last;
      assign pipe_any = 1'b0;
    end else begin : g_lat_pipe
      logic [RD_LAT-1:0] vld_q;
      logic [RD_LAT-1:0] fst_q;
      logic [RD_LAT-1:0] lst_q;

      // Shift issue flags one stage per cycle; reset flushes in-flight reads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
          fst_q <= '0;
          lst_q <= '0;
        end else begin
          vld_q[0] <= rd_fire;
          fst_q[0] <= rd_first;
          lst_q[0] <= rd_last;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            fst_q[i] <= fst_q[i-1];
            lst_q[i] <= lst_q[i-1];
          end
        end
      end

      assign pipe_vld = vld_q[RD_LAT-1];
      assign pipe_fst = fst_q[RD_LAT-1];
      assign pipe_lst = lst_q[RD_LAT-1];
      assign pipe_any = |vld_q;
    end
  endgenerate

  assign out_valid_o = rst_n & pipe_vld;
  assign out_first_o = rst_n & pipe_fst;
  assign out_last_o  = rst_n & pipe_lst;
  assign busy_o      = rst_n & ((state_q == ST_DRAIN) | pipe_any);

endmodule
`default_nettype wire

// File: tb/tb_dif_radix2_64p_da_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dif_radix2_64p_da_ctrl
//  Purpose  : Directed self-checking bench for dif_radix2_64p_da_ctrl
//             (RD_LAT = 1, IDLE_SEL = 8). Honours DIF_DA_CTRL_BITREV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dif_radix2_64p_da_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       in_last_o;
  logic       out_ready_i;
  logic       out_valid_o;
  logic       out_first_o;
  logic       out_last_o;
  logic [3:0] wen_ctrl_o;
  logic [2:0] waddr_ctrl_o;
  logic [3:0] ren_ctrl_o;
  logic [2:0] raddr_ctrl_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;

  dif_radix2_64p_da_ctrl #(
    .RD_LAT   (1),
    .IDLE_SEL (4'd8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_last_o    (in_last_o),
    .out_ready_i  (out_ready_i),
    .out_valid_o  (out_valid_o),
    .out_first_o  (out_first_o),
    .out_last_o   (out_last_o),
    .wen_ctrl_o   (wen_ctrl_o),
    .waddr_ctrl_o (waddr_ctrl_o),
    .ren_ctrl_o   (ren_ctrl_o),
    .raddr_ctrl_o (raddr_ctrl_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived (ren, raddr) pairs packed as {ren[3:0], raddr[2:0]}.
`ifdef DIF_DA_CTRL_BITREV_EN
  localparam int HAND_M_A = 1;  localparam logic [6:0] HAND_A = {4'd0, 3'd4};
  localparam int HAND_M_B = 6;  localparam logic [6:0] HAND_B = {4'd0, 3'd3};
`else
  localparam int HAND_M_A = 1;  localparam logic [6:0] HAND_A = {4'd0, 3'd1};
  localparam int HAND_M_B = 9;  localparam logic [6:0] HAND_B = {4'd1, 3'd1};
`endif
  localparam int HAND_M_C = 63; localparam logic [6:0] HAND_C = {4'd7, 3'd7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ren(input logic [5:0] m);
`ifdef DIF_DA_CTRL_BITREV_EN
    logic [5:0] n;
    n = {m[0], m[1], m[2], m[3], m[4], m[5]};
    return {1'b0, n[2:0]};
`else
    return {1'b0, m[5:3]};
`endif
  endfunction

  function automatic logic [2:0] exp_raddr(input logic [5:0] m);
`ifdef DIF_DA_CTRL_BITREV_EN
    logic [5:0] n;
    n = {m[0], m[1], m[2], m[3], m[4], m[5]};
    return n[5:3];
`else
    return m[2:0];
`endif
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready_o),   32'd1);
    chk({tag, "_in_last"},   32'(in_last_o),    32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid_o),  32'd0);
    chk({tag, "_out_first"}, 32'(out_first_o),  32'd0);
    chk({tag, "_out_last"},  32'(out_last_o),   32'd0);
    chk({tag, "_busy"},      32'(busy_o),       32'd0);
    chk({tag, "_wen"},       32'(wen_ctrl_o),   32'd8);
    chk({tag, "_waddr"},     32'(waddr_ctrl_o), 32'd0);
    chk({tag, "_ren"},       32'(ren_ctrl_o),   32'd8);
    chk({tag, "_raddr"},     32'(raddr_ctrl_o), 32'd0);
  endtask

  // Write nwr samples; gap=1 toggles in_valid 1,0,1,0...
  task automatic fill_frame(input int gap, input int nwr);
    int wr;
    int cyc;
    wr  = 0;
    cyc = 0;
    while (wr < nwr && cyc < 400) begin
      @(negedge clk);
      out_ready_i = 1'b0;
      in_valid_i  = (gap == 0) ? 1'b1 : ((cyc % 2) == 0);
      #1;
      chk("fill_in_ready", 32'(in_ready_o), 32'd1);
      chk("fill_wen",   32'(wen_ctrl_o),   in_valid_i ? 32'(wr % 8) : 32'd8);
      chk("fill_waddr", 32'(waddr_ctrl_o), 32'(wr / 8));
      chk("fill_in_last", 32'(in_last_o), 32'(in_valid_i && (wr == 63)));
      chk("fill_out_valid", 32'(out_valid_o), 32'd0);
      if (in_valid_i) wr++;
      cyc++;
    end
    if (wr < nwr) chk("fill_timeout", 32'(wr), 32'(nwr));
  endtask

  // Drain one frame; pat=1 applies the 1,1,0,0,1 out_ready pattern.
  task automatic drain_frame(input int pat);
    logic [4:0] stall_pat;
    int  m;
    int  cyc;
    bit  iss, prev_iss, prev_fst, prev_lst;
    stall_pat = 5'b10011;
    m = 0; cyc = 0;
    prev_iss = 1'b0; prev_fst = 1'b0; prev_lst = 1'b0;
    while ((m < 64 || prev_iss) && cyc < 400) begin
      @(negedge clk);
      in_valid_i  = (m < 64);   // must be ignored while draining
      out_ready_i = (m < 64) && ((pat == 0) ? 1'b1 : stall_pat[cyc % 5]);
      #1;
      iss = out_ready_i;
      chk("drain_in_ready", 32'(in_ready_o), (m < 64) ? 32'd0 : 32'd1);
      chk("drain_wen", 32'(wen_ctrl_o), 32'd8);
      chk("drain_ren", 32'(ren_ctrl_o), iss ? 32'(exp_ren(6'(m))) : 32'd8);
      if (iss) chk("drain_raddr", 32'(raddr_ctrl_o), 32'(exp_raddr(6'(m))));
      if (iss && m == HAND_M_A) chk("rd_hand_a", 32'({ren_ctrl_o, raddr_ctrl_o}), 32'(HAND_A));
      if (iss && m == HAND_M_B) chk("rd_hand_b", 32'({ren_ctrl_o, raddr_ctrl_o}), 32'(HAND_B));
      if (iss && m == HAND_M_C) chk("rd_hand_c", 32'({ren_ctrl_o, raddr_ctrl_o}), 32'(HAND_C));
      chk("drain_out_valid", 32'(out_valid_o), 32'(prev_iss));
      chk("drain_out_first", 32'(out_first_o), 32'(prev_fst));
      chk("drain_out_last",  32'(out_last_o),  32'(prev_lst));
      chk("drain_busy", 32'(busy_o), 32'((m < 64) || prev_iss));
      prev_fst = iss && (m == 0);
      prev_lst = iss && (m == 63);
      prev_iss = iss;
      if (iss) m++;
      cyc++;
    end
    if (m < 64 || prev_iss) chk("drain_timeout", 32'(m), 32'd64);
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #1;
    chk("post_drain_busy", 32'(busy_o), 32'd0);
    chk("post_drain_out_valid", 32'(out_valid_o), 32'd0);
    chk("post_drain_in_ready", 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset("rst_released");

    // Back-to-back frame, continuous drain.
    fill_frame(0, 64);
    drain_frame(0);

    // Bubbled input, stalled drain.
    fill_frame(1, 64);
    drain_frame(1);

    // Reset asserted on write 30.
    fill_frame(0, 30);
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid_i = 1'b1;
    #1;
    check_reset("rst_midfill_held");
    @(negedge clk);
    rst_n      = 1'b1;
    in_valid_i = 1'b0;
    #1;
    check_reset("rst_midfill_after");
    fill_frame(0, 64);   // restarts at wen=0, waddr=0

    // Reset with reads in flight.
    repeat (5) begin
      @(negedge clk);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
    end
    #1;
    chk("pre_rst_out_valid", 32'(out_valid_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst_drain_held");
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready_i = 1'b0;
    #1;
    check_reset("rst_drain_after");

    // Full recovery frame.
    fill_frame(0, 64);
    drain_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
